// File: rtl/debug_trace_pkg.sv
// debug_trace_pkg: shared types and width helpers for the triggered trace buffer.
//   trace_state_e : capture FSM encoding (IDLE/ARMED/POST/DONE), also exported on the state port
//   DROP_W        : width of the saturating lost-sample counter
//   ch_w()        : channel-id width, never below 1 bit
//   entry_w()     : stored entry width, {[ts], ch_id, data}
// Optional feature macro: DEBUG_TRACE_TS_EN (adds a timestamp field to every entry).
package debug_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  localparam int DROP_W = 16;

`ifdef DEBUG_TRACE_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  function automatic int ch_w(int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int entry_w(int w, int cw, int ts_w);
    return w + cw + (TS_EN ? ts_w : 0);
  endfunction

endpackage

// File: rtl/debug_trace_arb.sv
// debug_trace_arb: fixed-priority channel arbiter, purely combinational.
//   q         in  NCH   qualified requests (valid & mask)
//   grant_vld out 1     any request present
//   grant_idx out CW    lowest-index requester
//   extra_cnt out PC_W  requests that lose this cycle (popcount-1, 0 when idle)
module debug_trace_arb
  import debug_trace_pkg::*;
#(
  parameter  int NCH  = 2,
  localparam int CW   = debug_trace_pkg::ch_w(NCH),
  localparam int PC_W = $clog2(NCH + 1)
) (
  input  logic [NCH-1:0]  q,
  output logic            grant_vld,
  output logic [CW-1:0]   grant_idx,
  output logic [PC_W-1:0] extra_cnt
);

  logic [PC_W-1:0] pop;

  // Scan high to low so the last hit (lowest index) wins.
  always_comb begin
    pop       = '0;
    grant_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (q[i]) begin
        pop       = pop + 1'b1;
        grant_idx = CW'(i);
      end
    end
    grant_vld = |q;
    extra_cnt = grant_vld ? pop - 1'b1 : '0;
  end

endmodule

// File: rtl/debug_trace_buf.sv
// debug_trace_buf: multi-channel triggered trace buffer (circular RAM, arm/trigger/post-count).
//   clk, rst          clock, synchronous active-high reset
//   arm, trig         start/restart capture pulse; level trigger honoured only in ARMED
//   post_cnt          entries kept after the trigger (latched on arm, clamped to DEPTH)
//   ch_valid/data/mask per-channel samples, channel i at ch_data[W*i +: W]
//   state, done       capture FSM state, done = (state == DONE)
//   wr_ptr, count     next physical slot, valid entries 0..DEPTH
//   drop_cnt          samples lost to arbitration, saturating
//   rd_idx, rd_data   oldest-first logical readback, one-cycle latency
//   mem_flat          raw RAM image, physical slot k at [ENTRY_W*k +: ENTRY_W]
// Optional feature macro: DEBUG_TRACE_TS_EN adds a TS_W-bit timestamp in the entry MSBs.
module debug_trace_buf
  import debug_trace_pkg::*;
#(
  parameter  int W       = 5,
  parameter  int DEPTH   = 32,
  parameter  int NCH     = 2,
  parameter  int TS_W    = 16,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int CW      = debug_trace_pkg::ch_w(NCH),
  localparam int ENTRY_W = debug_trace_pkg::entry_w(W, CW, TS_W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       trig,
  input  logic [ADDR_W:0]            post_cnt,
  input  logic [NCH-1:0]             ch_valid,
  input  logic [NCH*W-1:0]           ch_data,
  input  logic [NCH-1:0]             ch_mask,
  output logic [1:0]                 state,
  output logic                       done,
  output logic [ADDR_W-1:0]          wr_ptr,
  output logic [ADDR_W:0]            count,
  output logic [DROP_W-1:0]          drop_cnt,
  input  logic [ADDR_W-1:0]          rd_idx,
  output logic [ENTRY_W-1:0]         rd_data,
  output logic [ENTRY_W*DEPTH-1:0]   mem_flat
);

  localparam int            PC_W    = $clog2(NCH + 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  trace_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [ADDR_W:0]       post_q, post_d;
  logic [DROP_W-1:0]     drop_q, drop_d;
  logic [DROP_W:0]       drop_sum;
  logic [ENTRY_W-1:0]    rd_data_q, rd_data_d;
  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [ADDR_W-1:0]     phys;

  logic [NCH-1:0]        q;
  logic                  grant_vld;
  logic [CW-1:0]         grant_idx;
  logic [PC_W-1:0]       extra_cnt;
  logic [NCH-1:0][W-1:0] ch_data_a;
  logic [ENTRY_W-1:0]    entry;
  logic                  cap_act;
  logic                  wr_en;

  assign q         = ch_valid & ch_mask;
  assign ch_data_a = ch_data;

  debug_trace_arb #(.NCH(NCH)) u_arb (
    .q         (q),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx),
    .extra_cnt (extra_cnt)
  );

`ifdef DEBUG_TRACE_TS_EN
  logic [TS_W-1:0] ts_q, ts_d;

  // Timestamp restarts with each capture so entries read as offsets from arm.
  always_comb ts_d = arm ? '0 : ts_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end

  assign entry = {ts_q, grant_idx, ch_data_a[grant_idx]};
`else
  assign entry = {grant_idx, ch_data_a[grant_idx]};
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // arm wins over everything; POST ends on the write that consumes the last post credit.
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ARMED:   if (trig) state_d = (post_q == '0) ? DONE : POST;
        POST:    if (wr_en && post_q == ONE_C) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // The arm cycle itself never writes; it only resets the capture.
  always_comb begin
    cap_act = (state_q == ARMED) || (state_q == POST);
    wr_en   = cap_act && grant_vld && !arm;
    done    = (state_q == DONE);
  end

  // ---------------- pointers / counters ----------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    post_d   = post_q;
    drop_d   = drop_q;
    drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(extra_cnt);
    if (arm) begin
      wr_ptr_d = '0;
      count_d  = '0;
      drop_d   = '0;
      post_d   = (post_cnt > DEPTH_C) ? DEPTH_C : post_cnt;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;   // DEPTH is a power of two, wraps naturally
      if (count_q != DEPTH_C) count_d = count_q + 1'b1;
      drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      if (state_q == POST) post_d = post_q - 1'b1;
    end
  end

  // ---------------- readback ----------------
  // Once full, the oldest entry sits at wr_ptr; before that it is slot 0.
  always_comb begin
    phys      = (count_q == DEPTH_C) ? wr_ptr_q + rd_idx : rd_idx;
    rd_data_d = ({1'b0, rd_idx} < count_q) ? mem_q[phys] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      count_q   <= '0;
      post_q    <= '0;
      drop_q    <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      post_q    <= post_d;
      drop_q    <= drop_d;
      rd_data_q <= rd_data_d;
    end
  end

  // RAM is never cleared; count alone defines which slots are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= entry;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign mem_flat[ENTRY_W*k +: ENTRY_W] = mem_q[k];
  end

  assign state    = state_q;
  assign wr_ptr   = wr_ptr_q;
  assign count    = count_q;
  assign drop_cnt = drop_q;
  assign rd_data  = rd_data_q;

endmodule
